// File: rtl/maj_bist_checker_if.sv
// Control/status and core-side bundle for the majority-core BIST checker.
// The checker is the slave; the sequencer plus the majority core form the master.
interface maj_bist_checker_if #(
  parameter int N     = 63,
  parameter int CNT_W = 16,
  parameter int VEC_W = 32
);
  logic             start;
  logic             mode;
  logic [VEC_W-1:0] vec_count;
  logic [N-1:0]     x_out;
  logic             y_dut;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     first_err_vec;
  logic [5:0]       first_err_hw;
  logic [VEC_W-1:0] vec_idx;

  modport master (
    output start, mode, vec_count, y_dut,
    input  x_out, busy, done, pass, err_count, first_err_vec, first_err_hw, vec_idx
  );

  modport slave (
    input  start, mode, vec_count, y_dut,
    output x_out, busy, done, pass, err_count, first_err_vec, first_err_hw, vec_idx
  );
endinterface

// File: rtl/maj_bist_checker.sv
// BIST wrapper for the 63-input majority core: drives counter/LFSR vectors,
// checks y_dut against a two-stage popcount reference and tallies mismatches.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one vector per clock on x_out
// DRAIN | two cycles flushing the check pipeline
// DONE  | results held until next start
module maj_bist_checker #(
  parameter int             N         = 63,
  parameter int             THRESH    = 32,
  parameter int             CNT_W     = 16,
  parameter int             VEC_W     = 32,
  parameter logic [N-1:0]   LFSR_SEED = 63'h1
) (
  input logic               clk,
  input logic               rst_n,
  maj_bist_checker_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             NSLICE    = (N + 7) / 8;
  localparam logic [N-1:0]   ONE_X     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   SEED      = (LFSR_SEED == '0) ? ONE_X : LFSR_SEED;
  localparam logic [VEC_W-1:0] ONE_V   = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]     THRESH_HW = 6'(THRESH);

  logic [1:0]       state;
  logic             mode_r;
  logic [VEC_W-1:0] vec_total;
  logic [VEC_W-1:0] vec_idx;
  logic             drain_cnt;
  logic [N-1:0]     x_out;
  logic [N-1:0]     x_next;
  logic             pass;
  logic             accept;
  logic             last_vec;

  logic                  s1_valid;
  logic                  y_r;
  logic [N-1:0]          x_r;
  logic [NSLICE-1:0][3:0] part;
  logic [NSLICE-1:0][3:0] part_r;
  logic [8*NSLICE-1:0]   x_pad;
  logic [5:0]            hw;
  logic                  ref_bit;
  logic                  mismatch;

  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     first_err_vec;
  logic [5:0]       first_err_hw;

  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign last_vec = ((vec_idx + ONE_V) == vec_total);

  // Fibonacci LFSR x^63 + x^62 + 1, shifting left with feedback into bit 0
  always_comb begin
    if (mode_r) x_next = {x_out[N-2:0], x_out[N-1] ^ x_out[N-2]};
    else        x_next = x_out + ONE_X;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_r    <= 1'b0;
      vec_total <= '0;
      vec_idx   <= '0;
      drain_cnt <= 1'b0;
      x_out     <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            vec_idx <= '0;
            if (bus.vec_count == '0) begin
              state <= S_DONE;
              pass  <= 1'b1;
            end else begin
              state     <= S_RUN;
              mode_r    <= bus.mode;
              vec_total <= bus.vec_count;
              x_out     <= bus.mode ? SEED : '0;
              pass      <= 1'b0;
            end
          end
        end
        S_RUN: begin
          vec_idx <= vec_idx + ONE_V;
          if (last_vec) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b1;
          end else begin
            x_out <= x_next;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 1'b0) begin
            state <= S_DONE;
            pass  <= (err_count == '0);
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 partial popcounts; the top slice carries one zero pad bit
  always_comb begin
    x_pad        = '0;
    x_pad[N-1:0] = x_out;
    for (int s = 0; s < NSLICE; s++) part[s] = pop8(x_pad[8*s +: 8]);
  end

  always_comb begin
    hw = '0;
    for (int s = 0; s < NSLICE; s++) hw = hw + {2'b00, part_r[s]};
  end

  assign ref_bit  = (hw >= THRESH_HW);
  assign mismatch = s1_valid & (y_r != ref_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      y_r           <= 1'b0;
      x_r           <= '0;
      part_r        <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_hw  <= '0;
    end else begin
      s1_valid <= (state == S_RUN);
      if (state == S_RUN) begin
        y_r    <= bus.y_dut;
        x_r    <= x_out;
        part_r <= part;
      end
      if (accept) begin
        err_count     <= '0;
        first_err_vec <= '0;
        first_err_hw  <= '0;
      end else if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ONE_C;
        if (err_count == '0) begin
          first_err_vec <= x_r;
          first_err_hw  <= hw;
        end
      end
    end
  end

  assign bus.x_out         = x_out;
  assign bus.busy          = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done          = (state == S_DONE);
  assign bus.pass          = pass;
  assign bus.err_count     = err_count;
  assign bus.first_err_vec = first_err_vec;
  assign bus.first_err_hw  = first_err_hw;
  assign bus.vec_idx       = vec_idx;

endmodule

// File: tb/tb_maj_bist_checker.sv
// Bench for maj_bist_checker: table of runs with a result scoreboard, per-cycle
// vector replay, plus hand sequences for reset mid-run and counter saturation.
module tb_maj_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maj_bist_checker_if #(.N(63), .CNT_W(16), .VEC_W(32)) bus ();
  maj_bist_checker_if #(.N(63), .CNT_W(4),  .VEC_W(32)) bus4 ();

  maj_bist_checker #(.N(63), .THRESH(32), .CNT_W(16), .VEC_W(32), .LFSR_SEED(63'h1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  maj_bist_checker #(.N(63), .THRESH(32), .CNT_W(4), .VEC_W(32), .LFSR_SEED(63'h1))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // 0 = ideal majority, 1 = stuck at 0, 2 = inverted majority
  int ymodel = 0;
  assign bus.y_dut  = (ymodel == 0) ? ($countones(bus.x_out) >= 32) :
                      (ymodel == 1) ? 1'b0 : ($countones(bus.x_out) < 32);
  assign bus4.y_dut = ($countones(bus4.x_out) < 32);

  typedef struct {
    logic mode;
    int   vc;
    int   ym;
    int   pulse_at;
  } in_t;

  typedef struct {
    int          err;
    logic        pass;
    int          vidx;
    logic [62:0] last_x;
    logic [62:0] fvec;
    int          fhw;
    int          lat;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t ex;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [62:0] gen_next(input logic [62:0] x, input logic md);
    if (md) return {x[61:0], x[62] ^ x[61]};
    return x + 63'd1;
  endfunction

  function automatic exp_t model(input in_t in, input int cntmax);
    exp_t        e;
    logic [62:0] x;
    int          h;
    logic        r;
    logic        y;
    e.err = 0; e.pass = 1'b1; e.vidx = in.vc; e.last_x = '0;
    e.fvec = '0; e.fhw = 0; e.lat = (in.vc == 0) ? 0 : in.vc + 2;
    x = in.mode ? 63'h1 : 63'h0;
    for (int i = 0; i < in.vc; i++) begin
      h = $countones(x);
      r = (h >= 32);
      y = (in.ym == 0) ? r : (in.ym == 1) ? 1'b0 : ~r;
      if (y != r) begin
        if (e.err == 0) begin
          e.fvec = x;
          e.fhw  = h;
        end
        if (e.err < cntmax) e.err++;
      end
      e.last_x = x;
      x = gen_next(x, in.mode);
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic run_case(input in_t in, input exp_t ex);
    logic [62:0] xm;
    int          c;
    exp_t        e;
    ymodel = in.ym;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = in.mode; bus.vec_count = in.vc;
    sb_q.push_back(ex);
    @(negedge clk);
    bus.start = 1'b0;
    xm = in.mode ? 63'h1 : 63'h0;
    c = 0;
    while (bus.done !== 1'b1 && c < in.vc + 50) begin
      if (c < in.vc) begin
        check("x_out", {1'b0, bus.x_out}, {1'b0, xm});
        xm = gen_next(xm, in.mode);
      end
      check("vec_idx", {32'd0, bus.vec_idx}, (c < in.vc) ? 64'(c) : 64'(in.vc));
      if (c == in.pulse_at) begin
        bus.start = 1'b1; bus.mode = ~in.mode; bus.vec_count = 3;
      end else begin
        bus.start = 1'b0; bus.mode = in.mode; bus.vec_count = in.vc;
      end
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    e = sb_q.pop_front();
    check("done", {63'd0, bus.done}, 64'd1);
    check("latency", 64'(c), 64'(e.lat));
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    check("err_count", {48'd0, bus.err_count}, 64'(e.err));
    check("pass", {63'd0, bus.pass}, {63'd0, e.pass});
    check("vec_idx_final", {32'd0, bus.vec_idx}, 64'(e.vidx));
    check("x_out_final", {1'b0, bus.x_out}, {1'b0, e.last_x});
    check("first_err_vec", {1'b0, bus.first_err_vec}, {1'b0, e.fvec});
    check("first_err_hw", {58'd0, bus.first_err_hw}, 64'(e.fhw));
  endtask

  initial begin
    int c;
    bus.start = 1'b0; bus.mode = 1'b0; bus.vec_count = '0;
    bus4.start = 1'b0; bus4.mode = 1'b0; bus4.vec_count = '0;

    tbl[0].in = '{1'b0, 1000, 0, -1};
    tbl[0].ex = '{0, 1'b1, 1000, 63'd999, 63'd0, 0, 1002};
    tbl[1].in = '{1'b0, 0, 0, -1};
    tbl[1].ex = '{0, 1'b1, 0, 63'd999, 63'd0, 0, 0};
    tbl[2].in = '{1'b0, 100, 0, 30};
    tbl[2].ex = '{0, 1'b1, 100, 63'd99, 63'd0, 0, 102};
    tbl[3].in = '{1'b1, 20000, 0, -1};
    tbl[3].ex = model(tbl[3].in, 65535);
    tbl[4].in = '{1'b1, 5000, 1, -1};
    tbl[4].ex = model(tbl[4].in, 65535);

    repeat (3) @(negedge clk);
    check("rst_x_out", {1'b0, bus.x_out}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_pass", {63'd0, bus.pass}, 64'd0);
    check("rst_err", {48'd0, bus.err_count}, 64'd0);
    check("rst_vec_idx", {32'd0, bus.vec_idx}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_case(tbl[i].in, tbl[i].ex);
    check("stuck0_fails", {63'd0, bus.pass}, 64'd0);

    // reset asserted while vector 50 of 100 is on x_out
    ymodel = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.vec_count = 100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    check("x_before_rst", {1'b0, bus.x_out}, 64'd50);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_x_out", {1'b0, bus.x_out}, 64'd0);
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_vec_idx", {32'd0, bus.vec_idx}, 64'd0);
    check("midrst_err", {48'd0, bus.err_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    run_case('{1'b0, 100, 0, -1}, '{0, 1'b1, 100, 63'd99, 63'd0, 0, 102});

    // 4-bit error counter against an inverted core saturates at 15
    @(negedge clk);
    bus4.start = 1'b1; bus4.mode = 1'b0; bus4.vec_count = 20;
    @(negedge clk);
    bus4.start = 1'b0;
    c = 0;
    while (bus4.done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("sat_done", {63'd0, bus4.done}, 64'd1);
    check("sat_latency", 64'(c), 64'd22);
    check("sat_err", {60'd0, bus4.err_count}, 64'd15);
    check("sat_fvec", {1'b0, bus4.first_err_vec}, 64'd0);
    check("sat_fhw", {58'd0, bus4.first_err_hw}, 64'd0);
    check("sat_pass", {63'd0, bus4.pass}, 64'd0);
    check("sat_vec_idx", {32'd0, bus4.vec_idx}, 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
